// File: rtl/seq_gen101_tx_if.sv
// Valid/ready word handshake feeding the 101 pattern transmitter.
// The source drives the word; the transmitter answers with in_ready.
interface seq_gen101_tx_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_gen101_tx.sv
// Serial 101-pattern transmitter: shifts words out MSB-first with an idle gap,
// and runs an overlapping Mealy 101 reference model on the emitted x stream.
module seq_gen101_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_gen101_tx_if.slave     src,
    input  logic               clr,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               det_pulse,
    output logic [CNT_W-1:0]   det_cnt
);
    localparam int BW     = $clog2(WIDTH);
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int W_M1   = WIDTH - 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             x_reg;
    logic             x_valid_reg;
    logic             busy_reg;
    logic             h1_reg;
    logic             h0_reg;
    logic [CNT_W-1:0] det_cnt_reg;

    assign src.in_ready = (state_reg == S_IDLE);
    assign x            = x_reg;
    assign x_valid      = x_valid_reg;
    assign busy         = busy_reg;
    assign det_cnt      = det_cnt_reg;
    // Same-cycle pulse on the closing '1', like the Mealy detector it shadows.
    assign det_pulse    = x_reg & ~h1_reg & h0_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (src.in_valid) begin
                        state_reg   <= S_SHIFT;
                        x_reg       <= src.in_data[WIDTH-1];
                        shift_reg   <= {src.in_data[WIDTH-2:0], 1'b0};
                        bit_cnt_reg <= W_M1[BW-1:0];
                        x_valid_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // bit_cnt_reg counts bits still to follow the one on x.
                    if (bit_cnt_reg == '0) begin
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        if (GAP > 0) begin
                            state_reg   <= S_GAP;
                            gap_cnt_reg <= GAP_M1[GW-1:0];
                        end else begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        x_reg       <= shift_reg[WIDTH-1];
                        shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // History follows every x, idle and gap zeros included; clr only hits the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1_reg      <= 1'b0;
            h0_reg      <= 1'b0;
            det_cnt_reg <= '0;
        end else begin
            h1_reg <= x_reg;
            h0_reg <= h1_reg;
            if (clr) begin
                det_cnt_reg <= '0;
            end else if (det_pulse && (det_cnt_reg != CNT_MAX)) begin
                det_cnt_reg <= det_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_gen101_tx.sv
// Bench for seq_gen101_tx: scoreboarded word table on a GAP=1 instance plus
// hand-written boundary, saturation and clear sequences on a GAP=0, 2-bit-count instance.
module tb_seq_gen101_tx;
    localparam int W     = 8;
    localparam int GAP_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_gen101_tx_if #(.WIDTH(W)) ifa ();
    seq_gen101_tx_if #(.WIDTH(W)) ifb ();

    logic       clr_a, x_a, xv_a, busy_a, dp_a;
    logic [7:0] cnt_a;
    logic       clr_b, x_b, xv_b, busy_b, dp_b;
    logic [1:0] cnt_b;

    seq_gen101_tx #(.WIDTH(W), .GAP(GAP_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .src(ifa), .clr(clr_a), .x(x_a), .x_valid(xv_a),
        .busy(busy_a), .det_pulse(dp_a), .det_cnt(cnt_a)
    );

    seq_gen101_tx #(.WIDTH(W), .GAP(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .src(ifb), .clr(clr_b), .x(x_b), .x_valid(xv_b),
        .busy(busy_b), .det_pulse(dp_b), .det_cnt(cnt_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: per-cycle expectations pushed by the driver, popped at negedge.
    typedef struct packed {
        logic x;
        logic xv;
        logic busy;
    } cyc_t;
    cyc_t sb_q[$];
    bit   mon_en  = 1'b0;
    logic mh1     = 1'b0;
    logic mh0     = 1'b0;
    int   exp_cnt = 0;

    always @(negedge clk) begin
        cyc_t e;
        logic ep;
        if (mon_en) begin
            e = cyc_t'(3'b000);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            ep = e.x & ~mh1 & mh0;
            chk("a_x", x_a, e.x);
            chk("a_x_valid", xv_a, e.xv);
            chk("a_busy", busy_a, e.busy);
            chk("a_in_ready", ifa.in_ready, !e.busy);
            chk("a_det_pulse", dp_a, ep);
            chk("a_det_cnt", cnt_a, exp_cnt);
            if (ep && exp_cnt < 255) exp_cnt++;
            mh0 = mh1;
            mh1 = e.x;
        end
    end

    // Offer a word (in_valid stays high afterwards with junk data while shifting).
    task automatic send_a(input logic [7:0] w);
        int guard = 0;
        @(negedge clk);
        ifa.in_valid = 1'b1;
        ifa.in_data  = w;
        while (!ifa.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("a_accept", ifa.in_ready, 1);
        if (!ifa.in_ready) return;
        @(posedge clk);
        #1;
        for (int i = W - 1; i >= 0; i--) sb_q.push_back(cyc_t'{x: w[i], xv: 1'b1, busy: 1'b1});
        for (int i = 0; i < GAP_A; i++) sb_q.push_back(cyc_t'{x: 1'b0, xv: 1'b0, busy: 1'b1});
        ifa.in_data = 8'($urandom);
        $display("[TB] word %02h accepted at %0t", w, $time);
    endtask

    typedef struct {
        logic [7:0] data;
        int         pulses;
    } vec_t;
    vec_t tbl[8];

    logic       xs [1:18];
    logic       xvs[1:18];
    logic       dps[1:18];
    logic       rdy[1:18];
    logic [1:0] cns[1:18];

    initial begin
        int c_prev;
        tbl[0] = '{8'hA5, 2};
        tbl[1] = '{8'h55, 3};
        tbl[2] = '{8'hAA, 3};
        tbl[3] = '{8'hFF, 0};
        tbl[4] = '{8'h01, 0};
        tbl[5] = '{8'h80, 0};
        tbl[6] = '{8'h5A, 2};
        tbl[7] = '{8'hB7, 2};

        ifa.in_valid = 1'b0; ifa.in_data = '0; clr_a = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; clr_b = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_x", x_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_ready", ifa.in_ready, 1);
        chk("rst_a_cnt", cnt_a, 0);
        chk("rst_b_xv", xv_b, 0);
        chk("rst_b_cnt", cnt_b, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Word table, in_valid held high back to back.
        c_prev = 0;
        for (int i = 0; i < 8; i++) begin
            send_a(tbl[i].data);
            if (i > 0) chk($sformatf("pulses_%02h", tbl[i-1].data), cnt_a - c_prev, tbl[i-1].pulses);
            c_prev = int'(cnt_a);
        end
        ifa.in_valid = 1'b0;
        repeat (W + GAP_A + 2) @(posedge clk);
        #1;
        chk($sformatf("pulses_%02h", tbl[7].data), cnt_a - c_prev, tbl[7].pulses);

        // Asynchronous reset in the middle of 8'hFF.
        send_a(8'hFF);
        ifa.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_x", x_a, 0);
        chk("mid_rst_xv", xv_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        chk("mid_rst_ready", ifa.in_ready, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        mh1 = 1'b0; mh0 = 1'b0; exp_cnt = 0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        send_a(8'hA5);
        ifa.in_valid = 1'b0;
        repeat (W + GAP_A + 2) @(posedge clk);
        #1;
        chk("post_rst_cnt", cnt_a, 2);

        // GAP=0: 8'h01 then 8'h80 back to back, 101 across the idle cycle.
        chk("b_cnt_start", cnt_b, 0);
        @(negedge clk);
        ifb.in_valid = 1'b1;
        ifb.in_data  = 8'h01;
        chk("b_ready0", ifb.in_ready, 1);
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            xs[c] = x_b; xvs[c] = xv_b; dps[c] = dp_b; rdy[c] = ifb.in_ready;
            if (c == 1) ifb.in_data = 8'h80;
            if (c == 10) ifb.in_valid = 1'b0;
        end
        for (int c = 1; c <= 18; c++) begin
            chk($sformatf("b_bnd_x_c%0d", c), xs[c], (c == 8) || (c == 10));
            chk($sformatf("b_bnd_xv_c%0d", c), xvs[c], (c != 9) && (c != 18));
            chk($sformatf("b_bnd_dp_c%0d", c), dps[c], c == 10);
            chk($sformatf("b_bnd_rdy_c%0d", c), rdy[c], (c == 9) || (c == 18));
        end
        chk("b_bnd_cnt", cnt_b, 1);

        // Saturation: 8'hAA twice into a 2-bit counter.
        @(negedge clk); clr_b = 1'b1;
        @(negedge clk); clr_b = 1'b0;
        chk("b_clr", cnt_b, 0);
        ifb.in_valid = 1'b1;
        ifb.in_data  = 8'hAA;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            xs[c] = x_b; dps[c] = dp_b; cns[c] = cnt_b;
            if (c == 10) ifb.in_valid = 1'b0;
        end
        for (int c = 1; c <= 17; c++) begin
            if (c <= 8) chk($sformatf("b_sat_x_c%0d", c), xs[c], c % 2);
            if (c >= 10) chk($sformatf("b_sat_x_c%0d", c), xs[c], (c % 2) == 0);
            chk($sformatf("b_sat_dp_c%0d", c), dps[c],
                (c == 3) || (c == 5) || (c == 7) || (c == 12) || (c == 14) || (c == 16));
        end
        chk("b_sat_cnt_c4", cns[4], 1);
        chk("b_sat_cnt_c6", cns[6], 2);
        chk("b_sat_cnt_c8", cns[8], 3);
        chk("b_sat_cnt_c13", cns[13], 3);
        chk("b_sat_cnt_c15", cns[15], 3);
        chk("b_sat_cnt_c17", cns[17], 3);

        // clr coinciding with a pulse wins.
        @(negedge clk);
        ifb.in_valid = 1'b1;
        ifb.in_data  = 8'hAA;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            dps[c] = dp_b; cns[c] = cnt_b;
            if (c == 1) ifb.in_valid = 1'b0;
            if (c == 3) clr_b = 1'b1;
            if (c == 4) clr_b = 1'b0;
        end
        chk("b_clr_dp_c3", dps[3], 1);
        chk("b_clr_cnt_c3", cns[3], 3);
        chk("b_clr_cnt_c4", cns[4], 0);
        chk("b_clr_cnt_c6", cns[6], 1);
        chk("b_clr_cnt_c8", cns[8], 2);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
